// File: rtl/pipeline_ctrl_if.sv
// Hazard/memory handshake bundle between the pipeline datapath and pipeline_ctrl.
// master: datapath side (drives hazard and memory status, consumes controls).
// slave:  controller side.
interface pipeline_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic             ID_EX_MemRead_i;
  logic [4:0]       EX_RTaddr_i;
  logic [4:0]       ID_RSaddr_i;
  logic [4:0]       ID_RTaddr_i;
  logic             branch_taken_i;
  logic             dmem_req_i;
  logic             dmem_ack_i;
  logic             pc_write_o;
  logic             IF_ID_write_o;
  logic             IF_ID_flush_o;
  logic             ID_EX_bubble_o;
  logic             freeze_o;
  logic             err_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;

  modport master (
    output ID_EX_MemRead_i, EX_RTaddr_i, ID_RSaddr_i, ID_RTaddr_i,
    output branch_taken_i, dmem_req_i, dmem_ack_i,
    input  pc_write_o, IF_ID_write_o, IF_ID_flush_o, ID_EX_bubble_o,
    input  freeze_o, err_o, stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  ID_EX_MemRead_i, EX_RTaddr_i, ID_RSaddr_i, ID_RTaddr_i,
    input  branch_taken_i, dmem_req_i, dmem_ack_i,
    output pc_write_o, IF_ID_write_o, IF_ID_flush_o, ID_EX_bubble_o,
    output freeze_o, err_o, stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Sequencing controller for the 5-stage MIPS pipeline: load-use stalls, branch
// flushes, data-memory wait freezes and a sticky memory-timeout error.
// Optional feature macro: PIPE_CTRL_PERF_CNT_EN enables saturating stall/flush
// performance counters; when undefined the counter ports read 0.
// The interface instance must use the same CNT_W as this module.
module pipeline_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 200,
  parameter int unsigned TIMEOUT_W   = 8,
  parameter int unsigned CNT_W       = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  pipeline_ctrl_if.slave ctrl
);

  typedef enum logic [1:0] {StRun, StMemWait, StErr} state_e;

  localparam logic [TIMEOUT_W:0] TIMEOUT_LIM = (TIMEOUT_W + 1)'(MEM_TIMEOUT);

  state_e               r_state;
  logic [TIMEOUT_W-1:0] r_wait_cnt;
  logic                 r_err;

  logic                 w_waiting;
  logic                 w_in_err;
  logic                 w_freeze;
  logic                 w_lu;
  logic                 w_advance;
  logic                 w_bubble;
  logic                 w_flush;
  logic [TIMEOUT_W:0]   w_cnt_inc;
  logic [TIMEOUT_W-1:0] w_cnt_next;
  logic                 w_timeout;

  // Hazard decode and priority resolution: freeze > load-use > branch.
  always_comb begin
    w_waiting = ctrl.dmem_req_i && !ctrl.dmem_ack_i;
    w_in_err  = (r_state == StErr);
    w_freeze  = w_in_err || w_waiting;
    w_lu      = ctrl.ID_EX_MemRead_i && (ctrl.EX_RTaddr_i != 5'd0) &&
                ((ctrl.EX_RTaddr_i == ctrl.ID_RSaddr_i) ||
                 (ctrl.EX_RTaddr_i == ctrl.ID_RTaddr_i));
    w_advance = !w_freeze && !w_lu;
    w_bubble  = !w_freeze && w_lu;
    w_flush   = w_advance && ctrl.branch_taken_i;
  end

  // Wait-counter increment: saturates so it can never wrap, even with the
  // timeout disabled.
  always_comb begin
    w_cnt_inc  = {1'b0, r_wait_cnt} + (TIMEOUT_W + 1)'(1);
    w_cnt_next = w_cnt_inc[TIMEOUT_W] ? r_wait_cnt : w_cnt_inc[TIMEOUT_W-1:0];
    w_timeout  = (MEM_TIMEOUT != 32'd0) && w_waiting && (w_cnt_inc >= TIMEOUT_LIM);
  end

  // Memory-wait FSM with wait counter and sticky error flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= StRun;
      r_wait_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        StRun, StMemWait: begin
          // An ack or a dropped request both end the wait in an unfrozen cycle.
          if (w_waiting) begin
            r_wait_cnt <= w_cnt_next;
            if (w_timeout) begin
              r_state <= StErr;
              r_err   <= 1'b1;
            end else begin
              r_state <= StMemWait;
            end
          end else begin
            r_wait_cnt <= '0;
            r_state    <= StRun;
          end
        end
        StErr: begin
          r_state    <= StErr;
          r_wait_cnt <= '0;
          r_err      <= 1'b1;
        end
        default: begin
          r_state    <= StRun;
          r_wait_cnt <= '0;
          r_err      <= 1'b0;
        end
      endcase
    end
  end

  assign ctrl.pc_write_o     = w_advance;
  assign ctrl.IF_ID_write_o  = w_advance;
  assign ctrl.IF_ID_flush_o  = w_flush;
  assign ctrl.ID_EX_bubble_o = w_bubble;
  assign ctrl.freeze_o       = w_freeze;
  assign ctrl.err_o          = r_err;

`ifdef PIPE_CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic             w_stall;

  assign w_stall = w_freeze || w_bubble;

  // Saturating performance counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_flush && !(&r_flush_cnt)) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign ctrl.stall_cnt_o = r_stall_cnt;
  assign ctrl.flush_cnt_o = r_flush_cnt;
`else
  assign ctrl.stall_cnt_o = '0;
  assign ctrl.flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: reference model feeds an expectation
// queue at drive time; outputs are sampled on the falling edge and compared.
module tb_pipeline_ctrl;
  localparam int unsigned MEM_TIMEOUT = 4;
  localparam int unsigned TIMEOUT_W   = 3;
  localparam int unsigned CNT_W       = 4;
  localparam int          CNT_MAX     = (1 << CNT_W) - 1;
`ifdef PIPE_CTRL_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef logic [6+2*CNT_W-1:0] obs_t;
  typedef struct {
    logic       r;
    logic       ml;
    logic [4:0] ert;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       br;
    logic       req;
    logic       ack;
  } stim_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipeline_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipeline_ctrl #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .TIMEOUT_W  (TIMEOUT_W),
    .CNT_W      (CNT_W)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .ctrl (bus)
  );

  obs_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model state (0 run, 1 wait, 2 err) and its pending next values.
  int m_st = 0, m_w = 0, m_sc = 0, m_fc = 0;
  int n_st = 0, n_w = 0, n_sc = 0, n_fc = 0;

  function automatic obs_t observe();
    return {bus.pc_write_o, bus.IF_ID_write_o, bus.IF_ID_flush_o, bus.ID_EX_bubble_o,
            bus.freeze_o, bus.err_o, bus.stall_cnt_o, bus.flush_cnt_o};
  endfunction

  // Apply one cycle of inputs and queue the model's expected outputs.
  task automatic drive(input stim_t s);
    bit frz, lu, pcw, bub, fl;
    rst                 = s.r;
    bus.ID_EX_MemRead_i = s.ml;
    bus.EX_RTaddr_i     = s.ert;
    bus.ID_RSaddr_i     = s.rs;
    bus.ID_RTaddr_i     = s.rt;
    bus.branch_taken_i  = s.br;
    bus.dmem_req_i      = s.req;
    bus.dmem_ack_i      = s.ack;
    frz = (m_st == 2) || (s.req && !s.ack);
    lu  = s.ml && (s.ert != 0) && ((s.ert == s.rs) || (s.ert == s.rt));
    pcw = !frz && !lu;
    bub = !frz && lu;
    fl  = !frz && !lu && s.br;
    exp_q.push_back({pcw, pcw, fl, bub, frz, (m_st == 2), CNT_W'(m_sc), CNT_W'(m_fc)});
    if (s.r) begin
      n_st = 0; n_w = 0; n_sc = 0; n_fc = 0;
    end else begin
      n_st = m_st; n_w = m_w;
      if (m_st != 2) begin
        if (s.req && !s.ack) begin
          n_w  = m_w + 1;
          n_st = (MEM_TIMEOUT != 0 && n_w >= MEM_TIMEOUT) ? 2 : 1;
        end else begin
          n_w = 0; n_st = 0;
        end
      end
      n_sc = (PERF && (frz || bub) && m_sc < CNT_MAX) ? m_sc + 1 : m_sc;
      n_fc = (PERF && fl && m_fc < CNT_MAX) ? m_fc + 1 : m_fc;
    end
  endtask

  task automatic step();
    @(posedge clk);
    m_st = n_st; m_w = n_w; m_sc = n_sc; m_fc = n_fc;
    #1;
  endtask

  function automatic stim_t mk(input logic r, ml, input int ert, rs, rt,
                               input logic br, req, ack);
    stim_t s;
    s.r = r; s.ml = ml; s.ert = 5'(ert); s.rs = 5'(rs); s.rt = 5'(rt);
    s.br = br; s.req = req; s.ack = ack;
    return s;
  endfunction

  task automatic test_reset();
    obs_t g, e;
    drive(mk(1, 0, 0, 0, 0, 0, 0, 0));
    rst = 1'b1;
    step();
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    // The reset-cycle entry was for the initial unknown state; discard it.
    void'(exp_q.pop_front());
    e = exp_q.pop_front();
    g = observe();
    checks++;
    if (g !== e) begin
      failures++; $display("FAIL reset_model got=%b exp=%b", g, e);
    end
    checks++;
    if (g !== {2'b11, 4'b0000, {(2*CNT_W){1'b0}}}) begin
      failures++; $display("FAIL reset_const got=%b exp=%b", g, {2'b11, {(4+2*CNT_W){1'b0}}});
    end
    step();
  endtask

  task automatic test_load_use();
    stim_t s[8];
    obs_t  g, e;
    s[0] = mk(1, 0, 0, 0, 0, 0, 0, 0);
    s[1] = mk(0, 1, 8, 8, 0, 0, 0, 0);
    s[2] = mk(0, 1, 8, 3, 8, 0, 0, 0);
    s[3] = mk(0, 1, 0, 0, 0, 0, 0, 0);
    s[4] = mk(0, 0, 8, 8, 0, 0, 0, 0);
    s[5] = mk(0, 1, 8, 8, 0, 0, 1, 0);
    s[6] = mk(0, 1, 8, 8, 0, 0, 1, 1);
    s[7] = mk(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      drive(s[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      g = observe();
      checks++;
      if (g !== e) begin
        failures++; $display("FAIL load_use[%0d] got=%b exp=%b", i, g, e);
      end
      if (i == 1) begin
        checks++;
        if ({bus.ID_EX_bubble_o, bus.pc_write_o} !== 2'b10) begin
          failures++;
          $display("FAIL load_use_bubble got=%b exp=10", {bus.ID_EX_bubble_o, bus.pc_write_o});
        end
      end
      step();
    end
  endtask

  task automatic test_branch_lu();
    stim_t s[4];
    obs_t  g, e;
    s[0] = mk(1, 0, 0, 0, 0, 0, 0, 0);
    s[1] = mk(0, 1, 5, 5, 0, 1, 0, 0);
    s[2] = mk(0, 0, 5, 5, 0, 1, 0, 0);
    s[3] = mk(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      drive(s[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      g = observe();
      checks++;
      if (g !== e) begin
        failures++; $display("FAIL branch_lu[%0d] got=%b exp=%b", i, g, e);
      end
      if (i == 3) begin
        checks++;
        if (bus.flush_cnt_o !== CNT_W'(PERF ? 1 : 0)) begin
          failures++; $display("FAIL flush_cnt got=%0d exp=%0d", bus.flush_cnt_o, PERF ? 1 : 0);
        end
      end
      step();
    end
  endtask

  task automatic test_mem_wait();
    stim_t s[9];
    obs_t  g, e;
    s[0] = mk(1, 0, 0, 0, 0, 0, 0, 0);
    s[1] = mk(0, 0, 0, 0, 0, 0, 1, 0);
    s[2] = mk(0, 0, 0, 0, 0, 0, 1, 0);
    s[3] = mk(0, 0, 0, 0, 0, 0, 1, 1);
    s[4] = mk(0, 0, 0, 0, 0, 0, 0, 0);
    s[5] = mk(0, 0, 0, 0, 0, 0, 1, 0);
    s[6] = mk(0, 0, 0, 0, 0, 0, 0, 0);
    s[7] = mk(0, 0, 0, 0, 0, 0, 1, 1);
    s[8] = mk(0, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 9; i++) begin
      drive(s[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      g = observe();
      checks++;
      if (g !== e) begin
        failures++; $display("FAIL mem_wait[%0d] got=%b exp=%b", i, g, e);
      end
      if (i == 4) begin
        checks++;
        if (bus.stall_cnt_o !== CNT_W'(PERF ? 2 : 0) || bus.freeze_o !== 1'b0) begin
          failures++;
          $display("FAIL mem_wait_stall got=%0d/%b exp=%0d/0", bus.stall_cnt_o, bus.freeze_o,
                   PERF ? 2 : 0);
        end
      end
      step();
    end
  endtask

  task automatic test_timeout();
    stim_t s[15];
    obs_t  g, e;
    s[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 5; k++) s[k] = mk(0, 0, 0, 0, 0, 0, 1, 0);
    s[6]  = mk(0, 1, 8, 8, 0, 1, 0, 0);
    s[7]  = mk(1, 0, 0, 0, 0, 0, 0, 0);
    s[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0);
    s[9]  = mk(1, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 10; k <= 12; k++) s[k] = mk(0, 0, 0, 0, 0, 0, 1, 0);
    s[13] = mk(0, 0, 0, 0, 0, 0, 1, 1);
    s[14] = mk(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 15; i++) begin
      drive(s[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      g = observe();
      checks++;
      if (g !== e) begin
        failures++; $display("FAIL timeout[%0d] got=%b exp=%b", i, g, e);
      end
      if (i == 4 || i == 5) begin
        checks++;
        if (bus.err_o !== (i == 5)) begin
          failures++; $display("FAIL timeout_err[%0d] got=%b exp=%b", i, bus.err_o, (i == 5));
        end
      end
      if (i == 8 || i == 14) begin
        checks++;
        if ({bus.err_o, bus.freeze_o, bus.pc_write_o} !== 3'b001) begin
          failures++;
          $display("FAIL timeout_recover[%0d] got=%b exp=001", i,
                   {bus.err_o, bus.freeze_o, bus.pc_write_o});
        end
      end
      step();
    end
  endtask

  task automatic test_saturation();
    stim_t s[22];
    obs_t  g, e;
    s[0] = mk(1, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 20; k++) s[k] = mk(0, 0, 0, 0, 0, 0, 1, 0);
    s[21] = mk(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 22; i++) begin
      drive(s[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      g = observe();
      checks++;
      if (g !== e) begin
        failures++; $display("FAIL saturation[%0d] got=%b exp=%b", i, g, e);
      end
      if (i == 21) begin
        checks++;
        if (bus.stall_cnt_o !== CNT_W'(PERF ? CNT_MAX : 0)) begin
          failures++;
          $display("FAIL stall_sat got=%0d exp=%0d", bus.stall_cnt_o, PERF ? CNT_MAX : 0);
        end
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    stim_t s;
    obs_t  g, e;
    for (int i = 0; i < 60; i++) begin
      s = mk(i == 0 || i == 30, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
      drive(s);
      @(negedge clk);
      e = exp_q.pop_front();
      g = observe();
      checks++;
      if (g !== e) begin
        failures++; $display("FAIL back_to_back[%0d] got=%b exp=%b", i, g, e);
      end
      step();
    end
  endtask

  initial begin
    rst                 = 1'b1;
    bus.ID_EX_MemRead_i = 1'b0;
    bus.EX_RTaddr_i     = '0;
    bus.ID_RSaddr_i     = '0;
    bus.ID_RTaddr_i     = '0;
    bus.branch_taken_i  = 1'b0;
    bus.dmem_req_i      = 1'b0;
    bus.dmem_ack_i      = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_load_use();
    test_branch_lu();
    test_mem_wait();
    test_timeout();
    test_saturation();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Sequencing controller for the 5-stage MIPS pipeline. It decides, every cycle, which pipeline registers advance, which hold, which take a bubble and which flush, based on load-use hazards, taken branches and a data-memory request/acknowledge handshake. It tracks multi-cycle memory waits in a small FSM, raises a sticky error on a memory timeout, and, when configured, keeps stall and flush performance counters. It sits beside the forwarding logic: forwarding resolves what it can, and this block stalls for everything else.

## Interface
- MEM_TIMEOUT, default 200: the number of consecutive unacknowledged memory-request cycles before the error state is entered. A value of 0 disables the timeout.
- TIMEOUT_W, default 8: width of the wait counter. Must satisfy 2^TIMEOUT_W > MEM_TIMEOUT.
- CNT_W, default 16: width of the performance counters.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset; synchronous and active-high.
- ID_EX_MemRead_i  in  1  the instruction in EX is a load.
- EX_RTaddr_i  in  5  load destination register in EX.
- ID_RSaddr_i, ID_RTaddr_i  in  5 each  source registers of the instruction in ID.
- branch_taken_i  in  1  a branch or jump resolved taken in ID.
- dmem_req_i  in  1  the MEM stage has a load or store outstanding.
- dmem_ack_i  in  1  data memory completes the access this cycle.
- pc_write_o  out  1  PC loads its next value.
- IF_ID_write_o  out  1  the IF/ID register loads.
- IF_ID_flush_o  out  1  the IF/ID register loads a NOP.
- ID_EX_bubble_o  out  1  zero the control bits entering ID/EX.
- freeze_o  out  1  hold ID/EX, EX/MEM and MEM/WB; suppress RegWrite and MemWrite side effects.
- err_o  out  1  sticky memory-timeout error.
- stall_cnt_o  out  CNT_W  stall-cycle counter.
- flush_cnt_o  out  CNT_W  flush counter.

## Operation
- **FSM states:** RUN, MEM_WAIT, ERR. Reset state is RUN.
- **Load-use hazard (lu):** ID_EX_MemRead_i && EX_RTaddr_i != 0 && (EX_RTaddr_i == ID_RSaddr_i || EX_RTaddr_i == ID_RTaddr_i). This term is combinational.
- **freeze:**
  - In RUN: dmem_req_i && !dmem_ack_i.
  - In MEM_WAIT: !dmem_ack_i && dmem_req_i.
  - In ERR: always 1.
- **Output priority:** freeze > lu > branch.
  - pc_write_o = IF_ID_write_o = !freeze && !lu.
  - ID_EX_bubble_o = !freeze && lu.
  - IF_ID_flush_o = !freeze && !lu && branch_taken_i. A branch that coincides with lu is retried after the stall.
- **FSM transitions:**
  - RUN → MEM_WAIT when dmem_req_i && !dmem_ack_i.
  - MEM_WAIT → RUN on dmem_ack_i. That cycle is unfrozen.
  - MEM_WAIT → RUN if dmem_req_i drops without an ack (abort). That cycle is unfrozen.
  - MEM_WAIT → ERR on timeout.
  - ERR persists until rst_i.
- **Wait counter:**
  - Counts consecutive unacknowledged request cycles, including the RUN cycle that triggers entry to MEM_WAIT.
  - Cleared in RUN when no request is waiting.
  - At the end of the MEM_TIMEOUT-th such cycle the FSM enters ERR.
  - The counter must never wrap.
- **ERR outputs:** err_o = 1, freeze_o = 1, and pc_write_o, IF_ID_write_o, IF_ID_flush_o and ID_EX_bubble_o all 0.

## Timing
- **Reset:** rst_i sampled high returns to RUN, clears the wait counter, err_o and both counters. Reset mid-wait or in ERR is the same.
- **Output values out of reset**, with all inputs 0: pc_write_o = 1, IF_ID_write_o = 1, all other outputs 0.
- **Latency:** all stall, flush and freeze outputs are combinational from the inputs and current state, valid in the same cycle as the inputs. err_o is registered and rises the cycle after the timeout cycle.
- **Single-cycle memory:** req and ack in the same cycle → no freeze, no state change.
- **Simultaneous events:**
  - lu + freeze: freeze only. lu re-evaluates after the freeze, so no bubble is lost.
  - ack on the timeout cycle: ack wins, RUN.

## Configuration
- **PIPE_CTRL_PERF_CNT_EN** defined:
  - stall_cnt_o increments each cycle with freeze_o || ID_EX_bubble_o.
  - flush_cnt_o increments each cycle with IF_ID_flush_o.
  - Both saturate at all-ones and clear on reset.
- **PIPE_CTRL_PERF_CNT_EN** undefined: the counter registers are absent and stall_cnt_o = flush_cnt_o = 0. The ports exist in both builds.

## Test plan
- **Reset:** rst_i high for 2 cycles, inputs 0 → pc_write_o = 1, IF_ID_write_o = 1, all other outputs 0, counters 0.
- **Load-use:** ID_EX_MemRead_i = 1, EX_RTaddr_i = 8, ID_RSaddr_i = 8 for one cycle → ID_EX_bubble_o = 1, pc_write_o = 0 that cycle. With EX_RTaddr_i = 0 → no stall.
- **Branch plus load-use:** branch_taken_i = 1 with lu active → flush 0, bubble 1. Next cycle lu cleared → IF_ID_flush_o = 1, flush_cnt_o = 1.
- **Memory wait:** dmem_req_i held, ack arrives on the 3rd cycle → freeze_o = 1 for cycles 1-2, 0 on cycle 3, state back to RUN, stall_cnt_o = 2.
- **Timeout:** MEM_TIMEOUT = 4, req held, ack never arrives → err_o = 1 from cycle 5, freeze_o stays 1. Asserting rst_i clears err_o and returns to RUN.
- **Saturation:** CNT_W = 4, macro defined, freeze held 20 cycles → stall_cnt_o = 15. Macro undefined → stall_cnt_o = 0.
